// File: rtl/reg_tdm_scanner.sv
// Purpose: snapshots N_CH channel registers and time-multiplexes them two per slot onto a 2*W word.
// Latency: a capture or advance shows on out/slot one edge after the causing input; out itself is a combinational mux.
// Backpressure: none; hold freezes the rotation, and step/force_load are sampled on every unheld edge.
module reg_tdm_scanner #(
  parameter int W      = 16,
  parameter int N_CH   = 3,
  parameter int DWELL  = 100000,
  localparam int N_SLOT = (N_CH + 1) / 2,
  localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_CH*W-1:0]   ch_in,
  input  logic                mode,
  input  logic                hold,
  input  logic                step,
  input  logic                force_load,
  output logic [2*W-1:0]      out,
  output logic [SLOT_W-1:0]   slot,
  output logic                frame_start
);

  // The snapshot is a power-of-two table indexed by {slot, half}. Entries at or
  // above N_CH are loaded from zero extension, so they always stay zero.
  localparam int N_ENT = 2 ** (SLOT_W + 1);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DWELL - 1);
  localparam bit ODD_CH = (N_CH % 2) == 1;

  logic [N_ENT*W-1:0] ch_ext;
  logic [W-1:0]       snap_q [N_ENT];
  logic [W-1:0]       snap_d [N_ENT];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               primed_q, primed_d;
  logic               fs_q, fs_d;
  logic               mode_q, mode_d;
  logic               advance, wrap, capture;
  logic [SLOT_W:0]    hi_idx, lo_idx;

  assign ch_ext = (N_ENT * W)'(ch_in);

  // Next-state logic for priming, dwell counting, slot advance and snapshot capture.
  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    primed_d = primed_q;
    fs_d     = 1'b0;
    mode_d   = mode;
    snap_d   = snap_q;
    advance  = 1'b0;
    wrap     = 1'b0;
    capture  = 1'b0;

    if (!primed_q) begin
      // First edge out of reset: take a frame snapshot and start at slot 0.
      primed_d = 1'b1;
      fs_d     = 1'b1;
      capture  = 1'b1;
      slot_d   = '0;
      cnt_d    = '0;
    end else if (hold) begin
      // Everything frozen; a mode change made while held takes effect after release.
      mode_d = mode_q;
    end else begin
      if (mode != mode_q) begin
        // Mode switch restarts the dwell count and never advances on the same edge.
        cnt_d = '0;
      end else if (mode) begin
        cnt_d   = '0;
        advance = step;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        advance = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      wrap = advance && (slot_q == LAST_SLOT);
      if (advance) begin
        slot_d = wrap ? '0 : slot_q + 1'b1;
      end
      // A wrap and a force_load on the same edge still give one capture, one pulse.
      fs_d    = wrap;
      capture = wrap || force_load;
    end

    if (capture) begin
      for (int i = 0; i < N_ENT; i++) begin
        snap_d[i] = ch_ext[i*W +: W];
      end
    end
  end

  // State registers; reset clears everything so out drops to zero immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      slot_q   <= '0;
      primed_q <= 1'b0;
      fs_q     <= 1'b0;
      mode_q   <= 1'b0;
      for (int i = 0; i < N_ENT; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      primed_q <= primed_d;
      fs_q     <= fs_d;
      mode_q   <= mode_d;
      snap_q   <= snap_d;
    end
  end

  // Slot k carries channel 2k in the high half and 2k+1 in the low half; an odd
  // last channel is moved to the low half with zero above it.
  always_comb begin
    hi_idx = {slot_q, 1'b0};
    lo_idx = {slot_q, 1'b1};
    if (ODD_CH && (slot_q == LAST_SLOT)) begin
      out = {{W{1'b0}}, snap_q[hi_idx]};
    end else begin
      out = {snap_q[hi_idx], snap_q[lo_idx]};
    end
  end

  assign slot        = slot_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_reg_tdm_scanner.sv
// Purpose: directed bench for reg_tdm_scanner (N_CH=3/DWELL=4 instance plus N_CH=1/DWELL=1 instance).
// Latency: inputs change #1 after a rising edge and outputs are sampled #1 after the following edge.
// Backpressure: not applicable; stimulus is a fixed timeline of directed vectors.
module tb_reg_tdm_scanner;

  logic        clk = 1'b0;

  // Instance A: W=16, N_CH=3, DWELL=4
  logic        rst_a_n;
  logic [47:0] ch_a;
  logic        mode_a, hold_a, step_a, fl_a;
  logic [31:0] out_a;
  logic [0:0]  slot_a;
  logic        fs_a;

  // Instance B: W=16, N_CH=1, DWELL=1
  logic        rst_b_n;
  logic [15:0] ch_b;
  logic        mode_b, hold_b, step_b, fl_b;
  logic [31:0] out_b;
  logic [0:0]  slot_b;
  logic        fs_b;

  int n_chk  = 0;
  int n_pass = 0;

  reg_tdm_scanner #(.W(16), .N_CH(3), .DWELL(4)) u_dut_a (
    .clk         (clk),
    .reset_n     (rst_a_n),
    .ch_in       (ch_a),
    .mode        (mode_a),
    .hold        (hold_a),
    .step        (step_a),
    .force_load  (fl_a),
    .out         (out_a),
    .slot        (slot_a),
    .frame_start (fs_a)
  );

  reg_tdm_scanner #(.W(16), .N_CH(1), .DWELL(1)) u_dut_b (
    .clk         (clk),
    .reset_n     (rst_b_n),
    .ch_in       (ch_b),
    .mode        (mode_b),
    .hold        (hold_b),
    .step        (step_b),
    .force_load  (fl_b),
    .out         (out_b),
    .slot        (slot_b),
    .frame_start (fs_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ch_a    = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    ch_b    = 16'hAAAA;
    mode_a  = 1'b0; hold_a = 1'b0; step_a = 1'b0; fl_a = 1'b0;
    mode_b  = 1'b0; hold_b = 1'b0; step_b = 1'b0; fl_b = 1'b0;
    tick(2);

    // Reset state
    chk("rst_out",  out_a, 64'h0);
    chk("rst_slot", slot_a, 64'h0);
    chk("rst_fs",   fs_a, 64'h0);
    chk("rst_b_out", out_b, 64'h0);

    // Priming edge
    rst_a_n = 1'b1;
    tick();
    chk("prime_out",  out_a, 64'hAAAABBBB);
    chk("prime_fs",   fs_a, 64'h1);
    chk("prime_slot", slot_a, 64'h0);
    tick();
    chk("prime_fs_one_cycle", fs_a, 64'h0);

    // Auto rotation: advance on the 4th edge after priming
    tick(3);
    chk("auto_slot1", slot_a, 64'h1);
    chk("auto_out1",  out_a, 64'h0000CCCC);
    ch_a[47:32] = 16'h1234;
    tick();
    chk("ch_change_isolated", out_a, 64'h0000CCCC);
    tick(3);
    chk("wrap_slot", slot_a, 64'h0);
    chk("wrap_fs",   fs_a, 64'h1);
    chk("wrap_out",  out_a, 64'hAAAABBBB);
    tick();
    chk("wrap_fs_one_cycle", fs_a, 64'h0);
    tick(3);
    chk("new_snap_slot", slot_a, 64'h1);
    chk("new_snap_out",  out_a, 64'h00001234);

    // Hold two cycles into slot 1 (cnt=2)
    tick(2);
    hold_a = 1'b1;
    ch_a[47:32] = 16'hFFFF;
    tick(10);
    chk("hold_slot", slot_a, 64'h1);
    chk("hold_out",  out_a, 64'h00001234);
    chk("hold_fs",   fs_a, 64'h0);
    hold_a = 1'b0;
    tick();
    chk("hold_rel_1", slot_a, 64'h1);
    tick();
    chk("hold_rel_2_slot", slot_a, 64'h0);
    chk("hold_rel_2_fs",   fs_a, 64'h1);
    chk("hold_rel_2_out",  out_a, 64'hAAAABBBB);

    // force_load mid-slot-0
    tick();
    ch_a[15:0] = 16'h5555;
    fl_a = 1'b1;
    tick();
    fl_a = 1'b0;
    chk("fl_out",  out_a, 64'h5555BBBB);
    chk("fl_slot", slot_a, 64'h0);
    chk("fl_fs",   fs_a, 64'h0);
    tick(2);
    chk("fl_slot1_out", out_a, 64'h0000FFFF);

    // force_load coinciding with a wrap edge
    ch_a = {16'h3333, 16'h2222, 16'h1111};
    tick(3);
    chk("pre_wrap_out", out_a, 64'h0000FFFF);
    fl_a = 1'b1;
    tick();
    fl_a = 1'b0;
    chk("flwrap_fs",   fs_a, 64'h1);
    chk("flwrap_slot", slot_a, 64'h0);
    chk("flwrap_out",  out_a, 64'h11112222);
    tick();
    chk("flwrap_fs_single", fs_a, 64'h0);

    // Manual mode
    mode_a = 1'b1;
    tick();
    chk("mode_chg_slot", slot_a, 64'h0);
    tick(20);
    chk("manual_idle_slot", slot_a, 64'h0);
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    chk("step1_slot", slot_a, 64'h1);
    chk("step1_fs",   fs_a, 64'h0);
    tick();
    chk("step1_stays", slot_a, 64'h1);
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    chk("step2_slot", slot_a, 64'h0);
    chk("step2_fs",   fs_a, 64'h1);
    tick();
    chk("step2_fs_one_cycle", fs_a, 64'h0);
    hold_a = 1'b1;
    step_a = 1'b1;
    tick();
    chk("step_held_slot", slot_a, 64'h0);
    chk("step_held_fs",   fs_a, 64'h0);
    hold_a = 1'b0;
    step_a = 1'b0;

    // Async reset mid-slot-1
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    chk("pre_arst_slot", slot_a, 64'h1);
    tick();
    rst_a_n = 1'b0;
    #2;
    chk("arst_out",  out_a, 64'h0);
    chk("arst_slot", slot_a, 64'h0);
    chk("arst_fs",   fs_a, 64'h0);
    tick();
    rst_a_n = 1'b1;
    tick();
    chk("reprime_out", out_a, 64'h11112222);
    chk("reprime_fs",  fs_a, 64'h1);

    // Instance B: N_CH=1, DWELL=1 -> every unheld edge wraps
    rst_b_n = 1'b1;
    tick();
    chk("b_prime_out", out_b, 64'h0000AAAA);
    chk("b_prime_fs",  fs_b, 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b_fs_every_cycle", fs_b, 64'h1);
    end
    ch_b = 16'h4321;
    tick();
    chk("b_out_recapture", out_b, 64'h00004321);
    chk("b_slot", slot_b, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
